// File: rtl/gba_gfx_pkg.sv
// Shared types for the per-dot layer resolution path: the pixel entry
// layout, layer identifiers, sorter FSM states and the priority key helper.
package gba_gfx_pkg;

    localparam int PIX_ENTRY_W    = 20;
    localparam int PIX_NUM_LAYERS = 5;
    localparam int PIX_COLOR_W    = 15;

    localparam logic [2:0] LAYER_BG0      = 3'd0;
    localparam logic [2:0] LAYER_BG1      = 3'd1;
    localparam logic [2:0] LAYER_BG2      = 3'd2;
    localparam logic [2:0] LAYER_BG3      = 3'd3;
    localparam logic [2:0] LAYER_OBJ      = 3'd4;
    localparam logic [2:0] LAYER_BACKDROP = 3'd5;

    // Backdrop always sits at the weakest priority level.
    localparam logic [1:0] BACKDROP_PRIO  = 2'b11;

    typedef struct packed {
        logic [1:0]             prio;
        logic [2:0]             layer;
        logic [PIX_COLOR_W-1:0] color;
    } pixel_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } sorter_state_t;

    // Entry that stands in for "nothing visible" at this dot.
    function automatic pixel_entry_t backdrop_entry(input logic [PIX_COLOR_W-1:0] color);
        pixel_entry_t e;
        e.prio  = BACKDROP_PRIO;
        e.layer = LAYER_BACKDROP;
        e.color = color;
        return e;
    endfunction

    // Ordering key: the backdrop flag sits above prio so any real layer,
    // whatever its prio, ranks ahead of the backdrop. Smaller key wins.
    function automatic logic [2:0] entry_key(input pixel_entry_t e);
        return {(e.layer == LAYER_BACKDROP), e.prio};
    endfunction

endpackage

// File: rtl/prio_key_compare.sv
// Combinational priority compare: does a visible candidate displace the
// incumbent entry? Ties go to the incumbent (strict less-than), which is
// what makes earlier-scanned layers win equal-prio contests.
import gba_gfx_pkg::*;

module prio_key_compare (
    input  logic         visible,
    input  pixel_entry_t cand,
    input  pixel_entry_t incumbent,
    output logic         beats
);

    // Candidate wins only if visible and strictly stronger.
    always_comb begin
        beats = visible && (entry_key(cand) < entry_key(incumbent));
    end

endmodule

// File: rtl/pixel_priority_sorter.sv
// Per-dot layer resolution: captures the five layer candidates of one dot
// plus backdrop, scans them serially (OBJ, BG0, BG1, BG2, BG3) and yields the
// top and second visible entries for the colour special-effects stage.
//
// Build option PRIO_SECOND_LAYER_EN: when defined, second_pixel tracks the
// next visible entry underneath top. When undefined, the second-slot compare
// is absent and second_pixel is simply the backdrop entry of the captured dot.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | in_ready high, waiting for a dot; results register initialised
//         | to backdrop on accept
// ST_SCAN | one candidate compared per cycle, cnt_q counts down 4..0
// ST_DONE | results presented with out_valid, held until out_ready
import gba_gfx_pkg::*;

module pixel_priority_sorter #(
    parameter int ENTRY_W    = PIX_ENTRY_W,
    parameter int NUM_LAYERS = PIX_NUM_LAYERS
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_LAYERS*ENTRY_W-1:0] cand,
    input  logic [NUM_LAYERS-1:0]         opaque,
    input  logic [NUM_LAYERS-1:0]         mask,
    input  logic [PIX_COLOR_W-1:0]        backdrop,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ENTRY_W-1:0]            top_pixel,
    output logic [ENTRY_W-1:0]            second_pixel
);

    sorter_state_t                 state;
    logic [2:0]                    cnt_q;
    logic [NUM_LAYERS*ENTRY_W-1:0] cand_q;
    logic [NUM_LAYERS-1:0]         vis_q;
    pixel_entry_t                  top_q;
    pixel_entry_t                  second_q;

    logic [2:0]                    slot;
    pixel_entry_t                  cur_entry;
    logic                          cur_vis;
    logic                          beats_top;

    // Map the down-counter onto scan order: 4 -> OBJ, then 3..0 -> BG0..BG3.
    always_comb begin
        slot      = (cnt_q == 3'd4) ? LAYER_OBJ : (3'd3 - cnt_q);
        cur_entry = pixel_entry_t'(cand_q[int'(slot)*ENTRY_W +: ENTRY_W]);
        cur_vis   = vis_q[slot];
    end

    prio_key_compare u_cmp_top (
        .visible   (cur_vis),
        .cand      (cur_entry),
        .incumbent (top_q),
        .beats     (beats_top)
    );

`ifdef PRIO_SECOND_LAYER_EN
    logic beats_second;

    prio_key_compare u_cmp_second (
        .visible   (cur_vis),
        .cand      (cur_entry),
        .incumbent (second_q),
        .beats     (beats_second)
    );
`endif

    // Sorter FSM: capture, serial scan, then hold results until accepted.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            cnt_q     <= '0;
            cand_q    <= '0;
            vis_q     <= '0;
            top_q     <= '0;
            second_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        cand_q   <= cand;
                        vis_q    <= opaque & mask;
                        top_q    <= backdrop_entry(backdrop);
                        second_q <= backdrop_entry(backdrop);
                        cnt_q    <= 3'd4;
                        in_ready <= 1'b0;
                        state    <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
`ifdef PRIO_SECOND_LAYER_EN
                    if (beats_top) begin
                        second_q <= top_q;
                        top_q    <= cur_entry;
                    end else if (beats_second) begin
                        second_q <= cur_entry;
                    end
`else
                    if (beats_top) begin
                        top_q <= cur_entry;
                    end
`endif
                    if (cnt_q == 3'd0) begin
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

    // Results come straight from the working registers; they only move in SCAN.
    always_comb begin
        top_pixel    = top_q;
        second_pixel = second_q;
    end

endmodule

// File: tb/tb_pixel_priority_sorter.sv
// Self-checking bench for pixel_priority_sorter: directed dots for the
// documented scenarios followed by randomized dots, checked against a
// queue-based model that picks the earliest-scanned minimum-prio entries.
module tb_pixel_priority_sorter;

    logic         clock;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [99:0]  cand;
    logic [4:0]   opaque;
    logic [4:0]   mask;
    logic [14:0]  backdrop;
    logic         out_valid;
    logic         out_ready;
    logic [19:0]  top_pixel;
    logic [19:0]  second_pixel;

    int vectors;
    int miscompares;

    pixel_priority_sorter dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .cand         (cand),
        .opaque       (opaque),
        .mask         (mask),
        .backdrop     (backdrop),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .top_pixel    (top_pixel),
        .second_pixel (second_pixel)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [19:0] mk_entry(input int prio, input int layer, input int color);
        logic [19:0] e;
        e = {2'(prio), 3'(layer), 15'(color)};
        return e;
    endfunction

    // Reference: gather visible layers in scan order, top = first with the
    // lowest prio, second = first lowest among the rest; backdrop otherwise.
    task automatic model(input logic [99:0] c, input logic [4:0] vis, input logic [14:0] bd,
                         output logic [19:0] t, output logic [19:0] s);
        logic [19:0] q[$];
        int ord[5] = '{4, 0, 1, 2, 3};
        int ti;
        int si;
        logic [19:0] bde;
        bde = {2'b11, 3'd5, bd};
        for (int k = 0; k < 5; k++)
            if (vis[ord[k]]) q.push_back(c[ord[k]*20 +: 20]);
        ti = -1;
        for (int i = 0; i < q.size(); i++)
            if (ti < 0 || q[i][19:18] < q[ti][19:18]) ti = i;
        t = (ti >= 0) ? q[ti] : bde;
        s = bde;
        si = -1;
`ifdef PRIO_SECOND_LAYER_EN
        for (int i = 0; i < q.size(); i++)
            if (i != ti && (si < 0 || q[i][19:18] < q[si][19:18])) si = i;
        if (si >= 0) s = q[si];
`endif
    endtask

    task automatic scramble_inputs();
        logic [127:0] tmp;
        tmp      = {$urandom(), $urandom(), $urandom(), $urandom()};
        cand     = tmp[99:0];
        opaque   = 5'($urandom());
        mask     = 5'($urandom());
        backdrop = 15'($urandom());
    endtask

    // One complete dot: accept, scan, optional DONE hold, handshake.
    task automatic run_dot(input string tag, input logic [99:0] c, input logic [4:0] op,
                           input logic [4:0] mk, input logic [14:0] bd,
                           input int hold, input bit poke,
                           output logic [19:0] got_t, output logic [19:0] got_s);
        logic [19:0] et;
        logic [19:0] es;
        int cyc;
        model(c, op & mk, bd, et, es);
        @(negedge clock);
        cand = c; opaque = op; mask = mk; backdrop = bd;
        in_valid = 1'b1; out_ready = 1'b0;
        check_val({tag, "_rdy_idle"}, 32'(in_ready), 32'd1);
        @(posedge clock); #1;
        in_valid = 1'b0;
        scramble_inputs();
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            in_valid = (poke && cyc == 1) ? 1'b1 : 1'b0;
            @(posedge clock); #1;
            cyc++;
        end
        in_valid = 1'b0;
        check_val({tag, "_latency"}, 32'(cyc), 32'd5);
        check_val({tag, "_top"}, 32'(top_pixel), 32'(et));
        check_val({tag, "_second"}, 32'(second_pixel), 32'(es));
        check_val({tag, "_rdy_done"}, 32'(in_ready), 32'd0);
        got_t = top_pixel;
        got_s = second_pixel;
        for (int h = 0; h < hold; h++) begin
            @(posedge clock); #1;
            check_val({tag, "_hold_top"}, 32'(top_pixel), 32'(et));
            check_val({tag, "_hold_second"}, 32'(second_pixel), 32'(es));
            check_val({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check_val({tag, "_hold_rdy"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        check_val({tag, "_post_valid"}, 32'(out_valid), 32'd0);
        check_val({tag, "_post_rdy"}, 32'(in_ready), 32'd1);
    endtask

    logic [99:0] c;
    logic [19:0] rt;
    logic [19:0] rs;
    int accepts[$];
    int cyc_idx;
    int budget;

    initial begin
        vectors = 0;
        miscompares = 0;
        reset_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        cand = '0; opaque = '0; mask = '0; backdrop = '0;
        repeat (3) @(posedge clock);
        #1;
        check_val("reset_rdy", 32'(in_ready), 32'd1);
        check_val("reset_valid", 32'(out_valid), 32'd0);
        check_val("reset_top", 32'(top_pixel), 32'd0);
        check_val("reset_second", 32'(second_pixel), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // Only BG2 visible.
        c = {mk_entry(0, 4, 15'h0111), mk_entry(2, 3, 15'h0333), mk_entry(1, 2, 15'h1234),
             mk_entry(0, 1, 15'h0222), mk_entry(0, 0, 15'h0444)};
        run_dot("t1", c, 5'b11111, 5'b00100, 15'h7FFF, 0, 1'b0, rt, rs);
        check_val("t1_top_const", 32'(rt), 32'({2'd1, 3'd2, 15'h1234}));

        // OBJ and BG0 both prio 0: OBJ wins the tie.
        c = {mk_entry(0, 4, 15'h5555), mk_entry(3, 3, 15'h0003), mk_entry(3, 2, 15'h0002),
             mk_entry(3, 1, 15'h0001), mk_entry(0, 0, 15'h2AAA)};
        run_dot("t2", c, 5'b10001, 5'b11111, 15'h0000, 0, 1'b0, rt, rs);
        check_val("t2_top_layer", 32'(rt[17:15]), 32'd4);

        // Everything masked off: backdrop in both slots.
        c = {mk_entry(0, 4, 15'h1111), mk_entry(0, 3, 15'h2222), mk_entry(0, 2, 15'h3333),
             mk_entry(0, 1, 15'h4444), mk_entry(0, 0, 15'h5555)};
        run_dot("t3", c, 5'b11111, 5'b00000, 15'h0ABC, 0, 1'b0, rt, rs);
        check_val("t3_top_const", 32'(rt), 32'({2'd3, 3'd5, 15'h0ABC}));

        // BG3 prio 0, BG1 prio 2, OBJ prio 3.
        c = {mk_entry(3, 4, 15'h0F0F), mk_entry(0, 3, 15'h3333), mk_entry(1, 2, 15'h7777),
             mk_entry(2, 1, 15'h1111), mk_entry(0, 0, 15'h6666)};
        run_dot("t4", c, 5'b11010, 5'b11111, 15'h0042, 0, 1'b0, rt, rs);
        check_val("t4_top_layer", 32'(rt[17:15]), 32'd3);

        // Downstream stall in DONE plus an in_valid pulse during SCAN.
        c = {mk_entry(1, 4, 15'h0123), mk_entry(2, 3, 15'h0456), mk_entry(0, 2, 15'h0789),
             mk_entry(1, 1, 15'h0ABC), mk_entry(3, 0, 15'h0DEF)};
        run_dot("t5", c, 5'b11111, 5'b11111, 15'h1357, 10, 1'b1, rt, rs);

        // Reset partway through a scan.
        @(negedge clock);
        cand = c; opaque = 5'b11111; mask = 5'b11111; backdrop = 15'h2468;
        in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b0;
        #1;
        check_val("t6_valid", 32'(out_valid), 32'd0);
        check_val("t6_top", 32'(top_pixel), 32'd0);
        check_val("t6_second", 32'(second_pixel), 32'd0);
        check_val("t6_rdy", 32'(in_ready), 32'd1);
        @(negedge clock);
        reset_n = 1'b1;
        run_dot("t6_next", c, 5'b01110, 5'b11011, 15'h0F00, 0, 1'b0, rt, rs);

        // Randomized dots.
        for (int n = 0; n < 40; n++) begin
            logic [99:0] rc;
            for (int l = 0; l < 5; l++)
                rc[l*20 +: 20] = mk_entry(int'($urandom_range(0, 3)), l, int'($urandom_range(0, 32767)));
            run_dot("rnd", rc, 5'($urandom()), 5'($urandom()), 15'($urandom()),
                    int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), rt, rs);
        end

        // Back-to-back throughput with both handshakes held high.
        @(negedge clock);
        in_valid = 1'b1;
        out_ready = 1'b1;
        cyc_idx = 0;
        repeat (40) begin
            if (in_ready) accepts.push_back(cyc_idx);
            @(negedge clock);
            cyc_idx++;
        end
        in_valid = 1'b0;
        check_val("tput_count", 32'(accepts.size()), 32'd6);
        for (int i = 1; i < accepts.size(); i++)
            check_val("tput_gap", 32'(accepts[i] - accepts[i-1]), 32'd7);
        budget = 0;
        while (!in_ready && budget < 20) begin
            @(negedge clock);
            budget++;
        end
        check_val("tput_drain", 32'(in_ready), 32'd1);
        out_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
